// File: rtl/rv_regfile_pkg.sv
// Shared constants and write-port arbitration helpers for the multi-port RISC-V register file.
package rv_regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int REG_ZERO  = 0;
    localparam int MAX_WP    = 32;

    // Highest-index set bit of a write-port hit mask; callers only use it when the mask is non-zero.
    function automatic int hi_port(input logic [MAX_WP-1:0] mask);
        int sel;
        sel = 0;
        for (int i = 0; i < MAX_WP; i++) begin
            if (mask[i]) sel = i;
        end
        return sel;
    endfunction

    function automatic logic multi_hit(input logic [MAX_WP-1:0] mask);
        return $countones(mask) > 1;
    endfunction

endpackage

// File: rtl/rv_regfile_mp_scoreboard.sv
// Destination scoreboard: one pending bit per architectural register, set on issue, cleared on write.
module rv_scoreboard
    import rv_regfile_pkg::*;
#(
    parameter  int NREGS = DEF_NREGS,
    parameter  int NWP   = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NWP-1:0]    i_wenb,
    input  logic [NWP*AW-1:0] i_waddr,
    input  logic              i_iss_enb,
    input  logic [AW-1:0]     i_iss_addr,
    output logic [NREGS-1:0]  o_pend,
    output logic [NREGS-1:0]  o_pend_nxt
);

    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_set;

    // The set term is ORed last so an issue beats a same-cycle write: it names the newer producer.
    always_comb begin
        w_clr = '0;
        w_set = '0;
        for (int i = 0; i < NWP; i++) begin
            if (i_wenb[i]) w_clr[i_waddr[i*AW +: AW]] = 1'b1;
        end
        if (i_iss_enb) w_set[i_iss_addr] = 1'b1;
        w_clr[REG_ZERO] = 1'b0;
        w_set[REG_ZERO] = 1'b0;
        o_pend_nxt = w_set | (r_pend & ~w_clr);
        o_pend_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= o_pend_nxt;
        end
    end

    assign o_pend = r_pend;

endmodule

// File: rtl/rv_regfile_mp.sv
// Multi-port integer register file: registered reads, optional write-to-read bypass,
// highest-port-wins write arbitration with conflict flag, and an in-flight destination scoreboard.
module rv_regfile_mp
    import rv_regfile_pkg::*;
#(
    parameter  int XLEN   = DEF_XLEN,
    parameter  int NREGS  = DEF_NREGS,
    parameter  int NRP    = 2,
    parameter  int NWP    = 1,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NRP-1:0]      renb,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*XLEN-1:0] rdata,
    output logic [NRP-1:0]      rbusy,
    input  logic [NWP-1:0]      wenb,
    input  logic [NWP*AW-1:0]   waddr,
    input  logic [NWP*XLEN-1:0] wdata,
    input  logic                iss_enb,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREGS-1:0]    pend,
    output logic                wconflict
);

    logic [XLEN-1:0]     r_regs [NREGS];
    logic [NRP*XLEN-1:0] r_rdata_p1;
    logic [NRP-1:0]      r_rbusy_p1;
    logic                r_wconflict_p1;

    logic [NWP-1:0]      w_hit    [NREGS];
    logic [XLEN-1:0]     w_wr_val [NREGS];
    logic [NREGS-1:0]    w_wr_en;
    logic [NREGS-1:0]    w_multi;
    logic [NREGS-1:0]    w_pend_nxt;
    logic [NRP*XLEN-1:0] w_rd_val;
    logic [NRP-1:0]      w_rd_busy;

    rv_scoreboard #(
        .NREGS (NREGS),
        .NWP   (NWP)
    ) u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_wenb     (wenb),
        .i_waddr    (waddr),
        .i_iss_enb  (iss_enb),
        .i_iss_addr (iss_addr),
        .o_pend     (pend),
        .o_pend_nxt (w_pend_nxt)
    );

    // Per-register write decode; x0 never matches, so it stays zero and never raises a conflict.
    always_comb begin
        for (int k = 0; k < NREGS; k++) begin
            w_hit[k] = '0;
            for (int i = 0; i < NWP; i++) begin
                w_hit[k][i] = wenb[i] && (waddr[i*AW +: AW] == AW'(k)) && (k != REG_ZERO);
            end
            w_wr_en[k]  = |w_hit[k];
            w_multi[k]  = multi_hit(MAX_WP'(w_hit[k]));
            w_wr_val[k] = wdata[hi_port(MAX_WP'(w_hit[k]))*XLEN +: XLEN];
        end
    end

    always_comb begin
        logic [AW-1:0] v_a;
        w_rd_val  = '0;
        w_rd_busy = '0;
        for (int p = 0; p < NRP; p++) begin
            v_a = raddr[p*AW +: AW];
            if ((BYPASS != 0) && w_wr_en[v_a]) begin
                w_rd_val[p*XLEN +: XLEN] = w_wr_val[v_a];
            end else begin
                w_rd_val[p*XLEN +: XLEN] = r_regs[v_a];
            end
            w_rd_busy[p] = (BYPASS != 0) ? w_pend_nxt[v_a] : pend[v_a];
        end
    end

    // Stage p1: storage update, registered read data/busy and the one-cycle conflict flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
            r_rdata_p1     <= '0;
            r_rbusy_p1     <= '0;
            r_wconflict_p1 <= 1'b0;
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                if (w_wr_en[k]) r_regs[k] <= w_wr_val[k];
            end
            for (int p = 0; p < NRP; p++) begin
                if (renb[p]) begin
                    r_rdata_p1[p*XLEN +: XLEN] <= w_rd_val[p*XLEN +: XLEN];
                    r_rbusy_p1[p]              <= w_rd_busy[p];
                end
            end
            r_wconflict_p1 <= |w_multi;
        end
    end

    assign rdata     = r_rdata_p1;
    assign rbusy     = r_rbusy_p1;
    assign wconflict = r_wconflict_p1;

endmodule

// File: tb/tb_rv_regfile_mp.sv
// Bench for rv_regfile_mp: a BYPASS=1 and a BYPASS=0 instance share all inputs (XLEN=64, NREGS=16, NRP=3, NWP=2).
module tb_rv_regfile_mp;

    logic         clk;
    logic         reset_n;
    logic [2:0]   renb;
    logic [11:0]  raddr;
    logic [1:0]   wenb;
    logic [7:0]   waddr;
    logic [127:0] wdata;
    logic         iss_enb;
    logic [3:0]   iss_addr;

    logic [191:0] rd_1, rd_0;
    logic [2:0]   bz_1, bz_0;
    logic [15:0]  pend_1, pend_0;
    logic         wc_1, wc_0;

    int n_pass  = 0;
    int n_total = 0;

    rv_regfile_mp #(.XLEN(64), .NREGS(16), .NRP(3), .NWP(2), .BYPASS(1)) dut_b1 (
        .clk(clk), .reset_n(reset_n), .renb(renb), .raddr(raddr), .rdata(rd_1), .rbusy(bz_1),
        .wenb(wenb), .waddr(waddr), .wdata(wdata), .iss_enb(iss_enb), .iss_addr(iss_addr),
        .pend(pend_1), .wconflict(wc_1)
    );

    rv_regfile_mp #(.XLEN(64), .NREGS(16), .NRP(3), .NWP(2), .BYPASS(0)) dut_b0 (
        .clk(clk), .reset_n(reset_n), .renb(renb), .raddr(raddr), .rdata(rd_0), .rbusy(bz_0),
        .wenb(wenb), .waddr(waddr), .wdata(wdata), .iss_enb(iss_enb), .iss_addr(iss_addr),
        .pend(pend_0), .wconflict(wc_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ren;
        logic [3:0]  ra;
        logic [1:0]  wen;
        logic [3:0]  wa0;
        logic [63:0] wd0;
        logic [3:0]  wa1;
        logic [63:0] wd1;
        logic        iss;
        logic [3:0]  ia;
        logic [63:0] e_rd1;
        logic [63:0] e_rd0;
        logic        e_b1;
        logic        e_b0;
        logic [15:0] e_pend;
        logic        e_wc;
    } vec_t;

    function automatic vec_t v(input logic ren, input logic [3:0] ra, input logic [1:0] wen,
                               input logic [3:0] wa0, input logic [63:0] wd0,
                               input logic [3:0] wa1, input logic [63:0] wd1,
                               input logic iss, input logic [3:0] ia,
                               input logic [63:0] e_rd1, input logic [63:0] e_rd0,
                               input logic e_b1, input logic e_b0,
                               input logic [15:0] e_pend, input logic e_wc);
        vec_t t;
        t.ren = ren; t.ra = ra; t.wen = wen; t.wa0 = wa0; t.wd0 = wd0; t.wa1 = wa1; t.wd1 = wd1;
        t.iss = iss; t.ia = ia; t.e_rd1 = e_rd1; t.e_rd0 = e_rd0; t.e_b1 = e_b1; t.e_b0 = e_b0;
        t.e_pend = e_pend; t.e_wc = e_wc;
        return t;
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        renb = '0; raddr = '0; wenb = '0; waddr = '0; wdata = '0; iss_enb = 1'b0; iss_addr = '0;
    endtask

    // Reference model: ports applied in ascending order so the highest index naturally wins.
    logic [63:0]  m_regs [16];
    logic [15:0]  m_pend;
    logic [191:0] m_rd1, m_rd0;
    logic [2:0]   m_bz1, m_bz0;
    logic         m_wc;

    task automatic model_reset();
        for (int k = 0; k < 16; k++) m_regs[k] = '0;
        m_pend = '0; m_rd1 = '0; m_rd0 = '0; m_bz1 = '0; m_bz0 = '0; m_wc = 1'b0;
    endtask

    task automatic model_edge();
        logic [63:0] nregs [16];
        logic [15:0] npend;
        logic [15:0] seen;
        logic        wc;
        logic [3:0]  a;
        nregs = m_regs; npend = m_pend; seen = '0; wc = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = waddr[i*4 +: 4];
            if (wenb[i] && a != 4'd0) begin
                if (seen[a]) wc = 1'b1;
                seen[a]  = 1'b1;
                nregs[a] = wdata[i*64 +: 64];
                npend[a] = 1'b0;
            end
        end
        if (iss_enb && iss_addr != 4'd0) npend[iss_addr] = 1'b1;
        for (int p = 0; p < 3; p++) begin
            a = raddr[p*4 +: 4];
            if (renb[p]) begin
                m_rd1[p*64 +: 64] = nregs[a];
                m_bz1[p]          = npend[a];
                m_rd0[p*64 +: 64] = m_regs[a];
                m_bz0[p]          = m_pend[a];
            end
        end
        m_regs = nregs; m_pend = npend; m_wc = wc;
    endtask

    localparam int NV = 17;
    vec_t tbl [NV];

    initial begin
        tbl[0]  = v(1, 7, 2'b01, 7, 64'h12345678, 0, 0, 0, 0, 64'h12345678, 64'h0, 0, 0, 16'h0, 0);
        tbl[1]  = v(1, 7, 2'b00, 0, 0, 0, 0, 0, 0, 64'h12345678, 64'h12345678, 0, 0, 16'h0, 0);
        tbl[2]  = v(1, 0, 2'b01, 0, 64'hFFFFFFFF_FFFFFFFF, 0, 0, 0, 0, 64'h0, 64'h0, 0, 0, 16'h0, 0);
        tbl[3]  = v(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 0, 0, 16'h0, 0);
        tbl[4]  = v(1, 3, 2'b11, 3, 64'h1, 3, 64'h2, 0, 0, 64'h2, 64'h0, 0, 0, 16'h0, 1);
        tbl[5]  = v(1, 3, 2'b00, 0, 0, 0, 0, 0, 0, 64'h2, 64'h2, 0, 0, 16'h0, 0);
        tbl[6]  = v(1, 5, 2'b11, 0, 64'hAAAA, 0, 64'hBBBB, 0, 0, 64'h0, 64'h0, 0, 0, 16'h0, 0);
        tbl[7]  = v(1, 4, 2'b11, 4, 64'hA, 5, 64'hB, 0, 0, 64'hA, 64'h0, 0, 0, 16'h0, 0);
        tbl[8]  = v(0, 5, 2'b00, 0, 0, 0, 0, 0, 0, 64'hA, 64'h0, 0, 0, 16'h0, 0);
        tbl[9]  = v(1, 5, 2'b00, 0, 0, 0, 0, 0, 0, 64'hB, 64'hB, 0, 0, 16'h0, 0);
        tbl[10] = v(1, 9, 2'b00, 0, 0, 0, 0, 1, 9, 64'h0, 64'h0, 1, 0, 16'h0200, 0);
        tbl[11] = v(1, 9, 2'b00, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 1, 1, 16'h0200, 0);
        tbl[12] = v(1, 9, 2'b10, 0, 0, 9, 64'h99, 0, 0, 64'h99, 64'h0, 0, 1, 16'h0, 0);
        tbl[13] = v(1, 9, 2'b01, 9, 64'h77, 0, 0, 1, 9, 64'h77, 64'h99, 1, 0, 16'h0200, 0);
        tbl[14] = v(1, 0, 2'b00, 0, 0, 0, 0, 1, 0, 64'h0, 64'h0, 0, 0, 16'h0200, 0);
        tbl[15] = v(0, 0, 2'b00, 0, 0, 0, 0, 1, 2, 64'h0, 64'h0, 0, 0, 16'h0204, 0);
        tbl[16] = v(1, 2, 2'b11, 9, 64'h55, 2, 64'h22, 0, 0, 64'h22, 64'h0, 0, 1, 16'h0, 0);

        idle();
        reset_n = 1'b0;
        step();
        step();
        check("reset rdata_b1", 256'(rd_1), 256'(0));
        check("reset rdata_b0", 256'(rd_0), 256'(0));
        check("reset pend/busy/wc", 256'({pend_1, pend_0, bz_1, bz_0, wc_1, wc_0}), 256'(0));
        #2 reset_n = 1'b1;
        step();

        for (int r = 0; r < NV; r++) begin
            renb = {2'b00, tbl[r].ren}; raddr = {8'h00, tbl[r].ra};
            wenb = tbl[r].wen; waddr = {tbl[r].wa1, tbl[r].wa0}; wdata = {tbl[r].wd1, tbl[r].wd0};
            iss_enb = tbl[r].iss; iss_addr = tbl[r].ia;
            step();
            check($sformatf("r%0d rd_b1", r), 256'(rd_1[63:0]), 256'(tbl[r].e_rd1));
            check($sformatf("r%0d rd_b0", r), 256'(rd_0[63:0]), 256'(tbl[r].e_rd0));
            check($sformatf("r%0d busy_b1", r), 256'(bz_1[0]), 256'(tbl[r].e_b1));
            check($sformatf("r%0d busy_b0", r), 256'(bz_0[0]), 256'(tbl[r].e_b0));
            check($sformatf("r%0d pend_b1", r), 256'(pend_1), 256'(tbl[r].e_pend));
            check($sformatf("r%0d pend_b0", r), 256'(pend_0), 256'(tbl[r].e_pend));
            check($sformatf("r%0d wc_b1", r), 256'(wc_1), 256'(tbl[r].e_wc));
            check($sformatf("r%0d wc_b0", r), 256'(wc_0), 256'(tbl[r].e_wc));
        end

        // Mid-run asynchronous reset after writing 0xDEADBEEF to x5 with a conflicting port.
        idle();
        renb = 3'b001; raddr = 12'h005;
        wenb = 2'b11; waddr = 8'h55; wdata = {64'hDEADBEEF, 64'h1111};
        iss_enb = 1'b1; iss_addr = 4'd6;
        step();
        check("pre-rst rd_b1", 256'(rd_1[63:0]), 256'(64'hDEADBEEF));
        check("pre-rst rd_b0", 256'(rd_0[63:0]), 256'(64'hB));
        check("pre-rst pend", 256'(pend_1), 256'(16'h0040));
        check("pre-rst wc", 256'({wc_1, wc_0}), 256'(2'b11));
        #1 reset_n = 1'b0;
        #1;
        check("async rst rdata", 256'({rd_1, rd_0}), 256'(0));
        check("async rst flags", 256'({pend_1, pend_0, bz_1, bz_0, wc_1, wc_0}), 256'(0));
        renb = 3'b111; raddr = 12'h555; wenb = 2'b11; waddr = 8'h57;
        wdata = {64'h1234, 64'h5678}; iss_enb = 1'b1; iss_addr = 4'd7;
        step();
        check("held rst rdata", 256'({rd_1, rd_0}), 256'(0));
        check("held rst flags", 256'({pend_1, pend_0, bz_1, bz_0, wc_1, wc_0}), 256'(0));
        #2 reset_n = 1'b1;
        idle();
        renb = 3'b011; raddr = 12'h075;
        step();
        check("post-rst x5/x7 b1", 256'(rd_1), 256'(0));
        check("post-rst x5/x7 b0", 256'(rd_0), 256'(0));
        check("post-rst pend", 256'({pend_1, pend_0}), 256'(0));

        // Random regression against the reference model.
        reset_n = 1'b0;
        idle();
        step();
        #2 reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < 10000; c++) begin
            renb     = 3'($urandom);
            raddr    = 12'($urandom);
            wenb     = 2'($urandom);
            waddr    = 8'($urandom);
            wdata    = {$urandom, $urandom, $urandom, $urandom};
            iss_enb  = 1'($urandom);
            iss_addr = 4'($urandom);
            model_edge();
            step();
            check($sformatf("rand%0d b1", c), 256'({rd_1, bz_1, pend_1, wc_1}),
                  256'({m_rd1, m_bz1, m_pend, m_wc}));
            check($sformatf("rand%0d b0", c), 256'({rd_0, bz_0, pend_0, wc_0}),
                  256'({m_rd0, m_bz0, m_pend, m_wc}));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
